seg7_char_receiver: RTL
=======================

// Module: seg7_char_receiver
// PURPOSE
//  Receive end of the 3-digit character display link: samples three active-low 7-segment buses,
//  filters glitches, decodes each pattern back to its 2-bit character code and emits one 6-bit
//  word per settled display change via valid/ready. Flags illegal patterns and one-step left rotation.
//  Sits between display-drive logic (or board loopback) and checker/score logic on the DE1-SoC.
// PARAMETERS
//  STABLE_CYCLES  4                      consecutive identical samples required before a digit is settled (>=1)
//  CNT_W          $clog2(STABLE_CYCLES+1) stability counter width
// PORTS
//  Clock      in   1  single system clock, all state on rising edge
//  Reset      in   1  asynchronous, active-high reset
//  HEX0_in    in   7  digit 0 segment pattern, active-low, bit0=a..bit6=g
//  HEX1_in    in   7  digit 1 segment pattern
//  HEX2_in    in   7  digit 2 segment pattern
//  word_out   out  6  {code2,code1,code0}, valid while word_valid=1
//  word_valid out  1  word_out/illegal/rotated held and valid
//  word_ready in   1  consumer accepts word on cycle with word_valid&word_ready
//  illegal    out  1  >=1 digit in presented word was not a legal pattern (its code reads 2'b11)
//  rotated    out  1  presented word == previous accepted word rotated left by one digit
//  overrun    out  1  sticky: a settled change was overwritten while a word was pending
// BEHAVIOUR
//  Encoding (active-low): 00->7'b0100100 '2', 01->7'b0010010 '5', 10->7'b0110000 '3', 11->7'b1111111 blank.
//  Any other pattern: code 2'b11, illegal=1 for that word.
//  Input registered once (1 cycle) before filtering; no other synchronisation stage.
//  Filter per digit: sample==prev sample -> count up, saturate at STABLE_CYCLES; differs -> count=0.
//   Digit settled when count==STABLE_CYCLES; settled code = decode(sample).
//  Word settled when all three digits settled. Candidate = settled {code2,code1,code0}+illegal.
//  FSM states:
//   WAIT: word settled AND candidate != last_word -> load output regs, go SHOW (word_valid=1 next cycle).
//   SHOW: word_valid=1, outputs frozen. valid&ready -> last_word<=word_out, go WAIT.
//    Any new differing settled candidate while in SHOW -> store in 1-entry pending reg (newest wins);
//    if pending already full, overrun<=1. After handshake, pending (if any) presented next cycle, else WAIT.
//  Latency: input change to word_valid = 1 (input reg) + STABLE_CYCLES + 1 cycles.
//  rotated computed at load: candidate == {last_word[3:0], last_word[5:4]}; 0 before first accepted word.
//  Candidate equal to last_word never produces a word (no duplicates, including after pending drain).
//  word_ready ignored when word_valid=0. Held ready with continuous changes: at most one word per 2 cycles.
//  Reset (any time, incl. mid-handshake): word_valid=0, word_out=6'b111111, illegal=0, rotated=0,
//   overrun=0, counters=0, pending empty, last_word=6'b111111 (all blank), has_prev=0, FSM=WAIT.
//   An all-blank display after reset therefore produces no word.
//  overrun cleared only by Reset.
// STRUCTURE
//  Include file seg7_chars.vh: localparams CH_2/CH_5/CH_3/CH_BLANK codes and PAT_* patterns; shared with
//   display encoder side.
//  Sub-module seg7_digit_filter (instanced x3): input reg, counter, settled flag, decode -> code, bad.
//  Top: word compare, FSM, pending register, rotation compare.
// TESTING
//  Reset, all HEX=7'h7F held 20 cycles -> word_valid stays 0, overrun=0.
//  HEX2/1/0 = '2','5','3' held, ready=1 -> word_out=6'b000110 after STABLE_CYCLES+2 cycles, one cycle valid.
//  Then '5','3','2' (left rotate) -> word 6'b011000, rotated=1; then '2','3','5' -> rotated=0.
//  HEX0 toggles every 2 cycles for 20 cycles (STABLE_CYCLES=4) -> no word; settles -> exactly one word.
//  HEX1=7'b0000000 -> word code1=2'b11, illegal=1; legal pattern restored -> new word, illegal=0.
//  ready=0, three distinct settled words -> first held, third replaces second in pending, overrun=1;
//   ready=1 -> first then third accepted; Reset asserted while valid -> all outputs to reset values next edge.

Source files
------------

// File: rtl/seg7_char_receiver_pkg.sv
// Shared character codes, segment patterns and helpers for the
// 3-digit 7-segment character link (receive side).
package seg7_char_receiver_pkg;

    localparam logic [1:0] CH_2     = 2'b00;
    localparam logic [1:0] CH_5     = 2'b01;
    localparam logic [1:0] CH_3     = 2'b10;
    localparam logic [1:0] CH_BLANK = 2'b11;

    // Active-low, bit0 = a .. bit6 = g
    localparam logic [6:0] PAT_2     = 7'b0100100;
    localparam logic [6:0] PAT_5     = 7'b0010010;
    localparam logic [6:0] PAT_3     = 7'b0110000;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    localparam logic [5:0] WORD_BLANK = 6'b111111;

    typedef enum logic {
        ST_WAIT,
        ST_SHOW
    } state_e;

    // Returns {bad, code}; unknown patterns read as blank and flag bad.
    function automatic logic [2:0] seg_decode(input logic [6:0] pat);
        logic [2:0] r;
        r = {1'b1, CH_BLANK};
        case (pat)
            PAT_2:     r = {1'b0, CH_2};
            PAT_5:     r = {1'b0, CH_5};
            PAT_3:     r = {1'b0, CH_3};
            PAT_BLANK: r = {1'b0, CH_BLANK};
            default:   r = {1'b1, CH_BLANK};
        endcase
        return r;
    endfunction

    // Word rotated left by one digit: {c1,c0,c2}
    function automatic logic [5:0] rotl_word(input logic [5:0] w);
        return {w[3:0], w[5:4]};
    endfunction

endpackage

// File: rtl/seg7_digit_filter.sv
// One display digit: input register, stability counter and decoder.
// The digit is settled once its sample has repeated STABLE_CYCLES times.
module seg7_digit_filter
    import seg7_char_receiver_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] hex_i,
    output logic [1:0] code_o,
    output logic       bad_o,
    output logic       settled_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]       sample_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       dec;

    // Count repeats of the incoming sample, restart on any difference
    always_comb begin
        cnt_d = cnt_q;
        if (hex_i != sample_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Sample register and counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sample_q <= PAT_BLANK;
            cnt_q    <= '0;
        end else begin
            sample_q <= hex_i;
            cnt_q    <= cnt_d;
        end
    end

    assign dec       = seg_decode(sample_q);
    assign code_o    = dec[1:0];
    assign bad_o     = dec[2];
    assign settled_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg7_char_receiver.sv
// Receive end of the 3-digit character link: filters three digits,
// presents each settled display change once over valid/ready.
module seg7_char_receiver
    import seg7_char_receiver_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [6:0] HEX0_in,
    input  logic [6:0] HEX1_in,
    input  logic [6:0] HEX2_in,
    output logic [5:0] word_out,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       illegal,
    output logic       rotated,
    output logic       overrun
);

    logic [6:0] hex_w  [3];
    logic [1:0] code_w [3];
    logic [2:0] bad_w;
    logic [2:0] settled_w;

    assign hex_w[0] = HEX0_in;
    assign hex_w[1] = HEX1_in;
    assign hex_w[2] = HEX2_in;

    for (genvar g = 0; g < 3; g++) begin : g_dig
        seg7_digit_filter #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_filt (
            .clk_i    (Clock),
            .rst_i    (Reset),
            .hex_i    (hex_w[g]),
            .code_o   (code_w[g]),
            .bad_o    (bad_w[g]),
            .settled_o(settled_w[g])
        );
    end

    logic [5:0] cand;
    logic       cand_bad;
    logic       all_settled;

    assign cand        = {code_w[2], code_w[1], code_w[0]};
    assign cand_bad    = |bad_w;
    assign all_settled = &settled_w;

    state_e     state_q, state_d;
    logic [5:0] out_q, out_d;
    logic       ill_q, ill_d;
    logic       rot_q, rot_d;
    logic       ovr_q, ovr_d;
    logic [5:0] pend_q, pend_d;
    logic       pbad_q, pbad_d;
    logic       pfull_q, pfull_d;
    logic [5:0] last_q, last_d;
    logic       hasp_q, hasp_d;

    // Next-state: load on new settled word, hold while shown, buffer one change
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ill_d   = ill_q;
        rot_d   = rot_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;
        pbad_d  = pbad_q;
        pfull_d = pfull_q;
        last_d  = last_q;
        hasp_d  = hasp_q;
        unique case (state_q)
            ST_WAIT: begin
                if (all_settled && cand != last_q) begin
                    out_d   = cand;
                    ill_d   = cand_bad;
                    rot_d   = hasp_q && (cand == rotl_word(last_q));
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (word_ready) begin
                    last_d = out_q;
                    hasp_d = 1'b1;
                    if (pfull_q) begin
                        out_d   = pend_q;
                        ill_d   = pbad_q;
                        rot_d   = (pend_q == rotl_word(out_q));
                        pfull_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (all_settled && cand != out_q &&
                             !(pfull_q && cand == pend_q)) begin
                    pend_d  = cand;
                    pbad_d  = cand_bad;
                    pfull_d = 1'b1;
                    if (pfull_q) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_WAIT;
            out_q   <= WORD_BLANK;
            ill_q   <= 1'b0;
            rot_q   <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= WORD_BLANK;
            pbad_q  <= 1'b0;
            pfull_q <= 1'b0;
            last_q  <= WORD_BLANK;
            hasp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ill_q   <= ill_d;
            rot_q   <= rot_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
            pbad_q  <= pbad_d;
            pfull_q <= pfull_d;
            last_q  <= last_d;
            hasp_q  <= hasp_d;
        end
    end

    assign word_valid = (state_q == ST_SHOW);
    assign word_out   = out_q;
    assign illegal    = ill_q;
    assign rotated    = rot_q;
    assign overrun    = ovr_q;

endmodule
